// File: rtl/peg_scorer.sv
// Sequential Mastermind scorer: exact pass over four positions, then a
// per-colour min-histogram pass for partials; registers pegs and game status.
module peg_scorer #(
  parameter int NUM_COLORS = 8,
  parameter int MAX_TURNS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       start,
  input  logic [2:0] code0,
  input  logic [2:0] code1,
  input  logic [2:0] code2,
  input  logic [2:0] code3,
  input  logic [2:0] guess0,
  input  logic [2:0] guess1,
  input  logic [2:0] guess2,
  input  logic [2:0] guess3,
  output logic       busy,
  output logic       done,
  output logic [2:0] exact,
  output logic [2:0] partial,
  output logic [1:0] fb0,
  output logic [1:0] fb1,
  output logic [1:0] fb2,
  output logic [1:0] fb3,
  output logic [3:0] turn_count,
  output logic       win,
  output logic       game_over
);

  localparam int CW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
  localparam logic [3:0]    NC    = 4'(NUM_COLORS);
  localparam logic [CW-1:0] CLAST = CW'(NUM_COLORS - 1);
  localparam logic [3:0]    MT    = 4'(MAX_TURNS);

  typedef enum logic [1:0] {IDLE, EXACT, COLOR} state_t;

  state_t state_q, state_d;
  logic [3:0][2:0] code_q, code_d;
  logic [3:0][2:0] guess_q, guess_d;
  logic [NUM_COLORS-1:0][2:0] chist_q, chist_d;
  logic [NUM_COLORS-1:0][2:0] ghist_q, ghist_d;
  logic [2:0] eacc_q, eacc_d;
  logic [2:0] pacc_q, pacc_d;
  logic [1:0] idx_q, idx_d;
  logic [CW-1:0] c_q, c_d;
  logic done_q, done_d;
  logic [2:0] exact_q, exact_d;
  logic [2:0] partial_q, partial_d;
  logic [3:0][1:0] fb_q, fb_d;
  logic [3:0] tc_q, tc_d;
  logic win_q, win_d;
  logic go_q, go_d;

  logic [2:0] cc, gg, ch, gh, mn, tot;
  logic [3:0] tc_new;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    guess_d   = guess_q;
    chist_d   = chist_q;
    ghist_d   = ghist_q;
    eacc_d    = eacc_q;
    pacc_d    = pacc_q;
    idx_d     = idx_q;
    c_d       = c_q;
    done_d    = 1'b0;
    exact_d   = exact_q;
    partial_d = partial_q;
    fb_d      = fb_q;
    tc_d      = tc_q;
    win_d     = win_q;
    go_d      = go_q;
    cc        = code_q[idx_q];
    gg        = guess_q[idx_q];
    ch        = chist_q[c_q];
    gh        = ghist_q[c_q];
    mn        = (ch < gh) ? ch : gh;
    tot       = '0;
    tc_new    = (tc_q == 4'd15) ? tc_q : tc_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        if (start && !go_q) begin
          code_d  = {code3, code2, code1, code0};
          guess_d = {guess3, guess2, guess1, guess0};
          chist_d = '0;
          ghist_d = '0;
          eacc_d  = '0;
          pacc_d  = '0;
          idx_d   = '0;
          state_d = EXACT;
        end
      end
      EXACT: begin
        if (cc == gg) begin
          eacc_d = eacc_q + 3'd1;
        end else begin
          if ({1'b0, cc} < NC) chist_d[cc] = chist_q[cc] + 3'd1;
          if ({1'b0, gg} < NC) ghist_d[gg] = ghist_q[gg] + 3'd1;
        end
        if (idx_q == 2'd3) begin
          c_d     = '0;
          state_d = COLOR;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      COLOR: begin
        pacc_d = pacc_q + mn;
        c_d    = c_q + CW'(1);
        if (c_q == CLAST) begin
          tot       = eacc_q + pacc_d;
          exact_d   = eacc_q;
          partial_d = pacc_d;
          for (int i = 0; i < 4; i++) begin
            if (3'(i) < eacc_q)   fb_d[i] = 2'd2;
            else if (3'(i) < tot) fb_d[i] = 2'd1;
            else                  fb_d[i] = 2'd0;
          end
          tc_d    = tc_new;
          win_d   = (eacc_q == 3'd4);
          go_d    = go_q | win_d | (tc_new == MT);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // new_game is a full soft reset, including abort of a running score
    if (new_game) begin
      state_d   = IDLE;
      code_d    = '0;
      guess_d   = '0;
      chist_d   = '0;
      ghist_d   = '0;
      eacc_d    = '0;
      pacc_d    = '0;
      idx_d     = '0;
      c_d       = '0;
      done_d    = 1'b0;
      exact_d   = '0;
      partial_d = '0;
      fb_d      = '0;
      tc_d      = '0;
      win_d     = 1'b0;
      go_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      code_q    <= '0;
      guess_q   <= '0;
      chist_q   <= '0;
      ghist_q   <= '0;
      eacc_q    <= '0;
      pacc_q    <= '0;
      idx_q     <= '0;
      c_q       <= '0;
      done_q    <= 1'b0;
      exact_q   <= '0;
      partial_q <= '0;
      fb_q      <= '0;
      tc_q      <= '0;
      win_q     <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      guess_q   <= guess_d;
      chist_q   <= chist_d;
      ghist_q   <= ghist_d;
      eacc_q    <= eacc_d;
      pacc_q    <= pacc_d;
      idx_q     <= idx_d;
      c_q       <= c_d;
      done_q    <= done_d;
      exact_q   <= exact_d;
      partial_q <= partial_d;
      fb_q      <= fb_d;
      tc_q      <= tc_d;
      win_q     <= win_d;
      go_q      <= go_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign exact      = exact_q;
  assign partial    = partial_q;
  assign fb0        = fb_q[0];
  assign fb1        = fb_q[1];
  assign fb2        = fb_q[2];
  assign fb3        = fb_q[3];
  assign turn_count = tc_q;
  assign win        = win_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_peg_scorer.sv
// Directed bench for peg_scorer: latency, scoring cases, start-while-busy,
// reset/new_game abort and turn exhaustion.
module tb_peg_scorer;

  logic       clk = 1'b0;
  logic       reset, new_game, start;
  logic [2:0] code0, code1, code2, code3;
  logic [2:0] guess0, guess1, guess2, guess3;
  logic       busy, done, win, game_over;
  logic [2:0] exact, partial;
  logic [1:0] fb0, fb1, fb2, fb3;
  logic [3:0] turn_count;

  int checks = 0;
  int errors = 0;
  int lat;
  logic seen;

  peg_scorer dut (
    .clk(clk), .reset(reset), .new_game(new_game), .start(start),
    .code0(code0), .code1(code1), .code2(code2), .code3(code3),
    .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .busy(busy), .done(done), .exact(exact), .partial(partial),
    .fb0(fb0), .fb1(fb1), .fb2(fb2), .fb3(fb3),
    .turn_count(turn_count), .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ops(input logic [11:0] c, input logic [11:0] g);
    {code3, code2, code1, code0}     = c;
    {guess3, guess2, guess1, guess0} = g;
  endtask

  // ticks until done or budget; n counts edges after the start edge
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic score(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, n);
  endtask

  task automatic quiet(input int n, output logic s);
    s = 1'b0;
    repeat (n) begin
      tick();
      if (done) s = 1'b1;
    end
  endtask

  task automatic res(input string tag, input logic [2:0] e,
                     input logic [2:0] p, input logic [7:0] f,
                     input logic w, input logic g, input logic [3:0] t);
    chk({tag, ".exact"}, 32'(exact), 32'(e));
    chk({tag, ".partial"}, 32'(partial), 32'(p));
    chk({tag, ".fb"}, 32'({fb3, fb2, fb1, fb0}), 32'(f));
    chk({tag, ".win"}, 32'(win), 32'(w));
    chk({tag, ".game_over"}, 32'(game_over), 32'(g));
    chk({tag, ".turns"}, 32'(turn_count), 32'(t));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    res(tag, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    reset = 1'b1; new_game = 1'b0; start = 1'b0;
    ops(12'h000, 12'h000);
    tick(); tick();
    reset = 1'b0;
    all_zero("reset");

    // win in one turn
    ops({3'd4, 3'd3, 3'd2, 3'd1}, {3'd4, 3'd3, 3'd2, 3'd1});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1.busy_after_start", 32'(busy), 32'd1);
    wait_done(0, lat);
    chk("t1.latency", 32'(lat), 32'd12);
    chk("t1.busy_at_done", 32'(busy), 32'd0);
    res("t1", 3'd4, 3'd0, {2'd2, 2'd2, 2'd2, 2'd2}, 1'b1, 1'b1, 4'd1);
    tick();
    chk("t1.done_one_cycle", 32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1.start_after_go_ignored", 32'(busy), 32'd0);
    quiet(15, seen);
    chk("t1.no_done_after_go", 32'(seen), 32'd0);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    all_zero("newgame1");

    // all colour-only matches
    ops({3'd2, 3'd2, 3'd1, 3'd1}, {3'd1, 3'd1, 3'd2, 3'd2});
    score(lat);
    chk("t2.latency", 32'(lat), 32'd12);
    res("t2", 3'd0, 3'd4, {2'd1, 2'd1, 2'd1, 2'd1}, 1'b0, 1'b0, 4'd1);

    // duplicates: one exact, two partial
    ops({3'd3, 3'd2, 3'd1, 3'd1}, {3'd1, 3'd1, 3'd2, 3'd1});
    score(lat);
    res("t3", 3'd1, 3'd2, {2'd0, 2'd1, 2'd1, 2'd2}, 1'b0, 1'b0, 4'd2);

    // second start plus guess change mid-score is ignored
    ops({3'd3, 3'd2, 3'd1, 3'd0}, {3'd0, 3'd1, 3'd2, 3'd3});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    ops({3'd3, 3'd2, 3'd1, 3'd0}, {3'd3, 3'd2, 3'd1, 3'd0});
    tick();
    start = 1'b0;
    wait_done(5, lat);
    chk("t4.latency", 32'(lat), 32'd12);
    res("t4", 3'd0, 3'd4, {2'd1, 2'd1, 2'd1, 2'd1}, 1'b0, 1'b0, 4'd3);
    quiet(15, seen);
    chk("t4.no_second_done", 32'(seen), 32'd0);

    // reset aborts a score at cycle 6
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    all_zero("t5.reset_abort");
    quiet(15, seen);
    chk("t5.reset_no_done", 32'(seen), 32'd0);

    // same with new_game, after building non-zero state
    ops({3'd3, 3'd2, 3'd1, 3'd1}, {3'd1, 3'd1, 3'd2, 3'd1});
    score(lat);
    res("t5.pre", 3'd1, 3'd2, {2'd0, 2'd1, 2'd1, 2'd2}, 1'b0, 1'b0, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    all_zero("t5.newgame_abort");
    quiet(15, seen);
    chk("t5.newgame_no_done", 32'(seen), 32'd0);

    // turn exhaustion
    ops(12'h000, {3'd1, 3'd1, 3'd1, 3'd1});
    for (int t = 1; t <= 8; t++) begin
      score(lat);
      chk("t6.latency", 32'(lat), 32'd12);
      chk("t6.turns", 32'(turn_count), 32'(t));
      chk("t6.game_over", 32'(game_over), 32'(t == 8));
    end
    res("t6.final", 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 4'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.ninth_ignored", 32'(busy), 32'd0);
    quiet(15, seen);
    chk("t6.ninth_no_done", 32'(seen), 32'd0);
    chk("t6.turns_hold", 32'(turn_count), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peg_scorer.md
Name: peg_scorer

Overview:
- Sequential Mastermind scoring engine. Sits between the committed-guess history and the seven-segment conversion path.
- On a start pulse it latches the secret code and the submitted guess, then counts exact (position+colour) and partial (colour-only) matches over a fixed number of cycles.
- Outputs per-digit peg codes for display, plus turn-count and win/game-over status.

Parameters:
- NUM_COLORS, 8: number of legal colours; code/guess values 0..NUM_COLORS-1.
- MAX_TURNS, 8: scored turns allowed before game over; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- new_game  input  1  one-cycle pulse; clears turn/game state
- start  input  1  one-cycle pulse; request scoring of current guess
- code0..code3  input  3 each  secret code, positions 0..3
- guess0..guess3  input  3 each  submitted guess, positions 0..3
- busy  output  1  high while scoring in progress
- done  output  1  one-cycle pulse when results update
- exact  output  3  exact-match count, 0..4
- partial  output  3  colour-only match count, 0..4
- fb0..fb3  output  2 each  display peg codes: 2 = exact, 1 = partial, 0 = none
- turn_count  output  4  completed scored turns
- win  output  1  last score had exact==4
- game_over  output  1  win or turns exhausted

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Priority: reset > new_game > start.
  - Reset: state IDLE; busy, done, exact, partial, fb0..fb3, turn_count, win, game_over all 0; histograms cleared.
  - new_game behaves identically to reset, including abort of an in-progress score.
- State machine:
  - IDLE:
    - start sampled high with game_over=0 at edge k: latch code0..3/guess0..3, clear both NUM_COLORS-entry histograms (3-bit entries) and exact accumulator, idx=0, go EXACT.
    - busy=1 from edge k.
    - start while game_over=1 is ignored.
  - EXACT: 4 edges (k+1..k+4), one position per edge.
    - If latched code[idx]==guess[idx]: exact_acc+1.
    - Else: code_hist[code[idx]]+1 and guess_hist[guess[idx]]+1. Values >= NUM_COLORS are not entered in the histograms.
    - After idx=3: go COLOR, c=0.
  - COLOR: NUM_COLORS edges (k+5..k+4+NUM_COLORS).
    - partial_acc += min(code_hist[c], guess_hist[c]).
    - On the edge processing c=NUM_COLORS-1, register all results in the same edge and return to IDLE:
      - exact, partial
      - fb
      - turn_count+1, saturating at 15
      - win = (exact==4)
      - game_over = win OR (new turn_count == MAX_TURNS)
      - done=1, busy=0
- Latency: done high exactly 4+NUM_COLORS edges after the start sample edge (12 for defaults), for exactly one cycle.
- start while busy: ignored; no queueing; latched operands unchanged.
- Input changes after the start edge do not affect the result.
- fb mapping: fb_i = 2 if i < exact; else 1 if i < exact+partial; else 0. fb0 is the first digit.
- exact+partial <= 4 always.
- Outputs hold the last result until the next done, reset, or new_game.
- Once game_over is set it stays set until reset/new_game.

Test Plan:
- code=1,2,3,4, guess=1,2,3,4, start -> done exactly 12 cycles later; exact=4, partial=0, fb=2,2,2,2, win=1, game_over=1, turn_count=1. A subsequent start is ignored (busy stays 0).
- code=1,1,2,2, guess=2,2,1,1 -> exact=0, partial=4, fb=1,1,1,1, win=0.
- code=1,1,2,3, guess=1,2,1,1 -> exact=1, partial=2, fb=2,1,1,0.
- start pulse, then a second start and changed guess at cycle 5 -> single done at cycle 12 with the original operands' result; no second done.
- reset asserted at cycle 6 of a score -> next cycle busy=0, all outputs 0, no done. Same stimulus with new_game gives identical behaviour.
- MAX_TURNS=8: eight non-winning scores (code=0,0,0,0, guess=1,1,1,1) -> turn_count steps 1..8; game_over=1 after the eighth done, win=0; a ninth start is ignored.
